axil_sort_engine: RTL and testbench
===================================

# axil_sort_engine

AXI4-Lite slave that classifies each written data word against a bank of programmable keys and pushes it into a match FIFO or a miss FIFO. It generalises the single-key sorter: keys, key width and FIFO depth are parameters, it supports both equality and range modes, and it adds an AXI4-Lite read channel that pops both FIFOs and reads back status. It sits on the peripheral AXI4-Lite bus and is the sorting front end of the data-sorter subsystem.

## Interface
- DATA_WIDTH, 32: AXI data width and FIFO word width.
- ADDR_WIDTH, 8: AXI address width. Byte addresses; bits [1:0] are ignored.
- KEY_WIDTH, 8: sort key width. The key is taken from WDATA[DATA_WIDTH-1 -: KEY_WIDTH].
- NUM_KEYS, 4: number of key registers. Range is 2..8.
- FIFO_DEPTH, 16: entries per FIFO. Must be a power of 2 and at least 2. CW = $clog2(FIFO_DEPTH)+1.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP[1:0]/BVALID/BREADY: AXI4-Lite write channels.
- ARADDR/ARVALID/ARREADY, RDATA/RRESP[1:0]/RVALID/RREADY: AXI4-Lite read channels.
- match_count, miss_count  out  CW  current occupancy of each FIFO.
- match_full, match_empty, miss_full, miss_empty  out  1  FIFO flags.

## Operation
Register map (byte offset):
- 0x00+4*i, KEY[i], RW: bits [KEY_WIDTH-1:0] hold the key; bit 31 is the enable bit.
- 0x20, CTRL, RW:
  - bit0 MODE: 0 = equality, 1 = range.
  - bit1 CLEAR: write-1 empties both FIFOs and zeroes the drop counter. It self-clears and always reads 0.
- 0x24, DATA_IN, WO: sorts WDATA. Reads return 0 with OKAY.
- 0x28, MATCH_POP, RO: pops the match FIFO.
- 0x2C, MISS_POP, RO: pops the miss FIFO.
- 0x30, STATUS, RO:
  - bit0 match_empty, bit1 match_full, bit2 miss_empty, bit3 miss_full.
  - [15:8] drop counter, 8-bit, saturating at 0xFF.
- 0x34, COUNTS, RO: match_count in [15:0], miss_count in [31:16], zero-extended.
- Any other address: DECERR (2'b11). Writes have no effect; reads return 0.

Sorting rules:
- Equality mode: the word is a match if any enabled KEY[i] equals the key field. If no key is enabled, every word is a miss.
- Range mode: the word is a match if KEY[0] ≤ key ≤ KEY[1], unsigned. Enable bits are ignored. If KEY[0] > KEY[1], every word is a miss.
- The target FIFO is full at the handshake cycle: the word is dropped, BRESP = SLVERR, and the drop counter increments. This holds even if the same FIFO is popped in that same cycle.
- Popping an empty FIFO: RDATA = 0, RRESP = SLVERR, no state change.
- WSTRB is ignored; every write is a full-word write.

Write FSM, states WIDLE and WRESP:
- WIDLE → WRESP in the cycle AWVALID and WVALID are both high. AWREADY and WREADY pulse together for that one cycle.
- AW and W may arrive in either order. Each is held pending, with its ready signal low, until the other arrives.
- WRESP → WIDLE on BVALID && BREADY.

Read FSM, states RIDLE and RDATA:
- RIDLE → RDATA on ARVALID. ARREADY is high in RIDLE.
- Pops and register samples happen at AR acceptance.
- RDATA → RIDLE on RVALID && RREADY.

Write and read FSMs run independently. Only one transaction per channel is outstanding.

## Timing
- Reset values:
  - all READY/VALID outputs 0, except ARREADY = 1 in RIDLE;
  - BRESP, RRESP and RDATA 0;
  - keys, CTRL and drop counter 0;
  - FIFOs empty: counts 0, empty = 1, full = 0;
  - FSMs in WIDLE/RIDLE.
- Write handshake at cycle T:
  - FIFO write, count update and register update are visible at T+1;
  - BVALID rises at T+1 and is held until BREADY;
  - the next AWREADY/WREADY is possible no earlier than the cycle after B completes.
- Read: AR accepted at T; RVALID and RDATA at T+1. The pop's count decrement is visible at T+1. RDATA is held stable until RREADY.
- Simultaneous push and pop on a non-full FIFO: count is unchanged and both operations take effect. A push to a full FIFO is always dropped.
- A KEY or CTRL write at T applies to DATA_IN writes handshaked at T+1 or later.
- CLEAR at T: FIFOs are empty at T+1. A pop accepted in the same cycle T returns the pre-clear head.
- Reset asserted mid-transaction aborts it immediately, with no B or R response. All state returns to reset values.
- Pointers wrap modulo FIFO_DEPTH. Counts range from 0 to FIFO_DEPTH inclusive.

## Structure
- Package axil_sort_pkg holds:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
  - register offset constants;
  - FSM state enums.
- Sub-module sort_fifo (synchronous FIFO; parameters WIDTH and DEPTH; push, pop, clear, count, full and empty) is instantiated twice.

## Test plan
- Equality sort: KEY0 = 0x800000A5, KEY1 = 0x800000A6. Write DATA_IN 0xA5000001, 0xA4000002, 0xA6000003 → match_count = 2, miss_count = 1. MATCH_POP returns 0xA5000001 then 0xA6000003, both OKAY.
- Range mode: CTRL = 1, KEY0 = 0x10, KEY1 = 0x20. Write 0x10…, 0x20…, 0x21…, 0x0F… → 2 matches and 2 misses, popped in FIFO order.
- Overflow: write 17 misses with FIFO_DEPTH = 16. The 17th gets BRESP = SLVERR, STATUS[15:8] = 1, miss_full = 1. Pop from an empty match FIFO gives RDATA = 0, RRESP = SLVERR.
- Handshake ordering: WVALID asserted 3 cycles before AWVALID → no ready before AWVALID, single-cycle AW/W ready, BVALID held for 4 cycles of BREADY = 0. Unmapped 0x40 gives DECERR on both write and read.
- Concurrency: the miss FIFO is full while a DATA_IN miss write and a MISS_POP are handshaked in the same cycle → write SLVERR, count 15, popped data correct.
- Reset and clear: assert rst low while BVALID is pending → BVALID = 0 at once and all counts 0. CLEAR with 5 entries → counts 0 the next cycle.

Source files
------------

// File: rtl/axil_sort_pkg.sv
// Shared constants for the AXI4-Lite sort engine: response codes, register
// offsets and FSM state encodings.
package axil_sort_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] OFF_KEY_BASE  = 32'h00;
  localparam logic [31:0] OFF_CTRL      = 32'h20;
  localparam logic [31:0] OFF_DATA_IN   = 32'h24;
  localparam logic [31:0] OFF_MATCH_POP = 32'h28;
  localparam logic [31:0] OFF_MISS_POP  = 32'h2C;
  localparam logic [31:0] OFF_STATUS    = 32'h30;
  localparam logic [31:0] OFF_COUNTS    = 32'h34;

  localparam logic [0:0] S_WIDLE = 1'b0;
  localparam logic [0:0] S_WRESP = 1'b1;
  localparam logic [0:0] S_RIDLE = 1'b0;
  localparam logic [0:0] S_RDATA = 1'b1;

endpackage

// File: rtl/sort_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO or a pop from
// an empty one is ignored, and clear empties it in one cycle.
module sort_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/axil_sort_engine.sv
// AXI4-Lite slave that classifies written words against programmable keys and
// queues them into a match FIFO or a miss FIFO, with pop/status reads.
module axil_sort_engine
  import axil_sort_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int KEY_WIDTH  = 8,
  parameter int NUM_KEYS   = 4,
  parameter int FIFO_DEPTH = 16,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [CW-1:0]           match_count,
  output logic [CW-1:0]           miss_count,
  output logic                    match_full,
  output logic                    match_empty,
  output logic                    miss_full,
  output logic                    miss_empty
);

  logic [0:0]            w_state;
  logic [0:0]            r_state;
  logic [KEY_WIDTH-1:0]  key_val [NUM_KEYS];
  logic [NUM_KEYS-1:0]   key_en;
  logic                  ctrl_mode;
  logic [7:0]            drop_cnt;

  logic [31:0]           wr_off;
  logic [31:0]           rd_off;
  logic                  wr_key_hit;
  logic                  rd_key_hit;
  logic                  wr_fire;
  logic                  ar_fire;
  logic [KEY_WIDTH-1:0]  in_key;
  logic                  is_match;
  logic                  match_push;
  logic                  miss_push;
  logic                  match_pop;
  logic                  miss_pop;
  logic                  clear;
  logic                  drop;
  logic [1:0]            wr_resp;
  logic [1:0]            rd_resp;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [DATA_WIDTH-1:0] match_rdata;
  logic [DATA_WIDTH-1:0] miss_rdata;
  logic                  unused_ok;

  assign unused_ok  = ^{wstrb, awaddr[1:0], araddr[1:0]};
  assign wr_off     = 32'({awaddr[ADDR_WIDTH-1:2], 2'b00});
  assign rd_off     = 32'({araddr[ADDR_WIDTH-1:2], 2'b00});
  assign wr_key_hit = (wr_off < OFF_KEY_BASE + 32'(4 * NUM_KEYS));
  assign rd_key_hit = (rd_off < OFF_KEY_BASE + 32'(4 * NUM_KEYS));

  // AW and W are accepted together only once both are valid.
  assign wr_fire = (w_state == S_WIDLE) && awvalid && wvalid;
  assign awready = wr_fire;
  assign wready  = wr_fire;
  assign bvalid  = (w_state == S_WRESP);
  assign arready = (r_state == S_RIDLE);
  assign ar_fire = arready && arvalid;
  assign rvalid  = (r_state == S_RDATA);

  assign in_key = wdata[DATA_WIDTH-1 -: KEY_WIDTH];

  // An inverted range (KEY0 > KEY1) can never match, which is the intended behaviour.
  always_comb begin
    is_match = 1'b0;
    if (ctrl_mode) begin
      is_match = (key_val[0] <= in_key) && (in_key <= key_val[1]);
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (key_en[i] && (key_val[i] == in_key)) is_match = 1'b1;
      end
    end
  end

  always_comb begin
    match_push = 1'b0;
    miss_push  = 1'b0;
    clear      = 1'b0;
    drop       = 1'b0;
    wr_resp    = RESP_OKAY;
    if (wr_off == OFF_CTRL) begin
      clear = wr_fire & wdata[1];
    end else if (wr_off == OFF_DATA_IN) begin
      if (is_match ? match_full : miss_full) begin
        drop    = wr_fire;
        wr_resp = RESP_SLVERR;
      end else if (is_match) begin
        match_push = wr_fire;
      end else begin
        miss_push = wr_fire;
      end
    end else if (!wr_key_hit && (wr_off != OFF_MATCH_POP) && (wr_off != OFF_MISS_POP) &&
                 (wr_off != OFF_STATUS) && (wr_off != OFF_COUNTS)) begin
      wr_resp = RESP_DECERR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state   <= S_WIDLE;
      bresp     <= RESP_OKAY;
      ctrl_mode <= 1'b0;
      drop_cnt  <= '0;
      key_en    <= '0;
      for (int i = 0; i < NUM_KEYS; i++) key_val[i] <= '0;
    end else begin
      if (w_state == S_WIDLE) begin
        if (wr_fire) begin
          w_state <= S_WRESP;
          bresp   <= wr_resp;
        end
      end else if (bready) begin
        w_state <= S_WIDLE;
      end
      if (wr_fire) begin
        for (int i = 0; i < NUM_KEYS; i++) begin
          if (wr_off == OFF_KEY_BASE + 32'(4 * i)) begin
            key_val[i] <= wdata[KEY_WIDTH-1:0];
            key_en[i]  <= wdata[DATA_WIDTH-1];
          end
        end
        if (wr_off == OFF_CTRL) ctrl_mode <= wdata[0];
      end
      if (clear)                             drop_cnt <= '0;
      else if (drop && (drop_cnt != 8'hFF))  drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Read values and pops are resolved at AR acceptance, so RDATA holds the
  // pre-clear head when a pop coincides with CLEAR.
  always_comb begin
    rd_val    = '0;
    rd_resp   = RESP_OKAY;
    match_pop = 1'b0;
    miss_pop  = 1'b0;
    if (rd_key_hit) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (rd_off == OFF_KEY_BASE + 32'(4 * i)) begin
          rd_val[KEY_WIDTH-1:0]  = key_val[i];
          rd_val[DATA_WIDTH-1]   = key_en[i];
        end
      end
    end else begin
      case (rd_off)
        OFF_CTRL:    rd_val[0] = ctrl_mode;
        OFF_DATA_IN: rd_val = '0;
        OFF_MATCH_POP: begin
          if (match_empty) rd_resp = RESP_SLVERR;
          else begin
            rd_val    = match_rdata;
            match_pop = ar_fire;
          end
        end
        OFF_MISS_POP: begin
          if (miss_empty) rd_resp = RESP_SLVERR;
          else begin
            rd_val   = miss_rdata;
            miss_pop = ar_fire;
          end
        end
        OFF_STATUS: begin
          rd_val[3:0]  = {miss_full, miss_empty, match_full, match_empty};
          rd_val[15:8] = drop_cnt;
        end
        OFF_COUNTS: begin
          rd_val[15:0]  = 16'(match_count);
          rd_val[31:16] = 16'(miss_count);
        end
        default: rd_resp = RESP_DECERR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RIDLE;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else if (r_state == S_RIDLE) begin
      if (arvalid) begin
        r_state <= S_RDATA;
        rdata   <= rd_val;
        rresp   <= rd_resp;
      end
    end else if (rready) begin
      r_state <= S_RIDLE;
    end
  end

  sort_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_match_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (match_push),
    .pop   (match_pop),
    .clear (clear),
    .wdata (wdata),
    .rdata (match_rdata),
    .count (match_count),
    .full  (match_full),
    .empty (match_empty)
  );

  sort_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_miss_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (miss_push),
    .pop   (miss_pop),
    .clear (clear),
    .wdata (wdata),
    .rdata (miss_rdata),
    .count (miss_count),
    .full  (miss_full),
    .empty (miss_empty)
  );

endmodule

// File: tb/tb_axil_sort_engine.sv
// Self-checking bench for axil_sort_engine: a table of AXI transactions with
// hand-computed results plus directed multi-cycle corner-case sequences.
module tb_axil_sort_engine;
  import axil_sort_pkg::*;

  localparam int TIMEOUT = 50;

  logic        clk;
  logic        rst_n;
  logic [7:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [4:0]  match_count;
  logic [4:0]  miss_count;
  logic        match_full;
  logic        match_empty;
  logic        miss_full;
  logic        miss_empty;

  int pass_count = 0;
  int check_count = 0;

  typedef struct {
    logic        is_read;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[$];

  axil_sort_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .awaddr      (awaddr),
    .awvalid     (awvalid),
    .awready     (awready),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .wvalid      (wvalid),
    .wready      (wready),
    .bresp       (bresp),
    .bvalid      (bvalid),
    .bready      (bready),
    .araddr      (araddr),
    .arvalid     (arvalid),
    .arready     (arready),
    .rdata       (rdata),
    .rresp       (rresp),
    .rvalid      (rvalid),
    .rready      (rready),
    .match_count (match_count),
    .miss_count  (miss_count),
    .match_full  (match_full),
    .match_empty (match_empty),
    .miss_full   (miss_full),
    .miss_empty  (miss_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    @(posedge clk); #1;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    #1;
    while (!(awready && wready) && n < TIMEOUT) begin @(posedge clk); #2; n++; end
    check_output("write accept in time", 32'(n < TIMEOUT), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < TIMEOUT) begin @(posedge clk); #1; n++; end
    resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    #1;
    while (!arready && n < TIMEOUT) begin @(posedge clk); #2; n++; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    while (!rvalid && n < TIMEOUT) begin @(posedge clk); #1; n++; end
    check_output("read complete in time", 32'(n < TIMEOUT), 32'd1);
    d = rdata;
    resp = rresp;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic add_w(input logic [7:0] a, input logic [31:0] d, input logic [1:0] r);
    vecs.push_back('{1'b0, a, d, r});
  endtask

  task automatic add_r(input logic [7:0] a, input logic [31:0] d, input logic [1:0] r);
    vecs.push_back('{1'b1, a, d, r});
  endtask

  task automatic apply_stimulus(input int idx, input vec_t v);
    logic [31:0] d;
    logic [1:0]  r;
    if (v.is_read) begin
      axi_read(v.addr, d, r);
      check_output($sformatf("vec%0d rdata @%h", idx, v.addr), d, v.data);
      check_output($sformatf("vec%0d rresp @%h", idx, v.addr), 32'(r), 32'(v.exp_resp));
    end else begin
      axi_write(v.addr, v.data, r);
      check_output($sformatf("vec%0d bresp @%h", idx, v.addr), 32'(r), 32'(v.exp_resp));
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic        early_ready;
    logic        b_drop;

    rst_n = 1'b0; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = 4'hF; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;

    // Equality sort, pops, status and key readback.
    add_r(8'h00, 32'h0, RESP_OKAY);
    add_r(8'h30, 32'h5, RESP_OKAY);
    add_w(8'h00, 32'h800000A5, RESP_OKAY);
    add_w(8'h04, 32'h800000A6, RESP_OKAY);
    add_w(8'h24, 32'hA5000001, RESP_OKAY);
    add_w(8'h24, 32'hA4000002, RESP_OKAY);
    add_w(8'h24, 32'hA6000003, RESP_OKAY);
    add_r(8'h34, 32'h00010002, RESP_OKAY);
    add_r(8'h28, 32'hA5000001, RESP_OKAY);
    add_r(8'h28, 32'hA6000003, RESP_OKAY);
    add_r(8'h28, 32'h0, RESP_SLVERR);
    add_r(8'h2C, 32'hA4000002, RESP_OKAY);
    add_r(8'h30, 32'h5, RESP_OKAY);
    add_r(8'h00, 32'h800000A5, RESP_OKAY);
    add_w(8'h08, 32'h000000A4, RESP_OKAY);
    add_w(8'h24, 32'hA4000004, RESP_OKAY);
    add_r(8'h34, 32'h00010000, RESP_OKAY);
    add_r(8'h2C, 32'hA4000004, RESP_OKAY);
    // Range mode, including the inclusive bounds and an inverted range.
    add_w(8'h20, 32'h1, RESP_OKAY);
    add_w(8'h00, 32'h10, RESP_OKAY);
    add_w(8'h04, 32'h20, RESP_OKAY);
    add_w(8'h24, 32'h10000001, RESP_OKAY);
    add_w(8'h24, 32'h20000002, RESP_OKAY);
    add_w(8'h24, 32'h21000003, RESP_OKAY);
    add_w(8'h24, 32'h0F000004, RESP_OKAY);
    add_r(8'h34, 32'h00020002, RESP_OKAY);
    add_r(8'h28, 32'h10000001, RESP_OKAY);
    add_r(8'h28, 32'h20000002, RESP_OKAY);
    add_r(8'h2C, 32'h21000003, RESP_OKAY);
    add_r(8'h2C, 32'h0F000004, RESP_OKAY);
    add_r(8'h20, 32'h1, RESP_OKAY);
    add_w(8'h00, 32'h30, RESP_OKAY);
    add_w(8'h24, 32'h25000005, RESP_OKAY);
    add_r(8'h34, 32'h00010000, RESP_OKAY);
    add_r(8'h2C, 32'h25000005, RESP_OKAY);
    // Address decode.
    add_w(8'h40, 32'h12345678, RESP_DECERR);
    add_r(8'h40, 32'h0, RESP_DECERR);
    add_r(8'h24, 32'h0, RESP_OKAY);
    add_r(8'h10, 32'h0, RESP_DECERR);
    add_r(8'h00, 32'h30, RESP_OKAY);
    add_w(8'h20, 32'h0, RESP_OKAY);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #2;
    check_output("reset arready", 32'(arready), 32'd1);
    check_output("reset ready/valid", 32'({awready, wready, bvalid, rvalid}), 32'd0);
    check_output("reset resp/rdata", rdata | 32'({bresp, rresp}), 32'd0);
    check_output("reset counts", 32'({match_count, miss_count}), 32'd0);
    check_output("reset flags", 32'({match_full, match_empty, miss_full, miss_empty}), 32'b0101);

    foreach (vecs[i]) apply_stimulus(i, vecs[i]);

    // Overflow: no key enabled and equality mode, so every word is a miss.
    for (int i = 0; i < 16; i++) begin
      axi_write(8'h24, 32'h01000000 + 32'(i), r);
      check_output($sformatf("fill %0d bresp", i), 32'(r), 32'(RESP_OKAY));
    end
    check_output("fill miss_full", 32'(miss_full), 32'd1);
    check_output("fill miss_count", 32'(miss_count), 32'd16);
    axi_write(8'h24, 32'h01000010, r);
    check_output("overflow bresp", 32'(r), 32'(RESP_SLVERR));
    check_output("overflow miss_count", 32'(miss_count), 32'd16);
    axi_read(8'h30, d, r);
    check_output("overflow status", d, 32'h00000109);
    axi_read(8'h28, d, r);
    check_output("empty pop rdata", d, 32'h0);
    check_output("empty pop rresp", 32'(r), 32'(RESP_SLVERR));

    // Concurrency: miss write and MISS_POP handshaked in the same cycle while full.
    @(posedge clk); #1;
    awaddr = 8'h24; wdata = 32'h77000000; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    araddr = 8'h2C; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check_output("concurrent bvalid", 32'(bvalid), 32'd1);
    check_output("concurrent bresp", 32'(bresp), 32'(RESP_SLVERR));
    check_output("concurrent rvalid", 32'(rvalid), 32'd1);
    check_output("concurrent rdata", rdata, 32'h01000000);
    check_output("concurrent rresp", 32'(rresp), 32'(RESP_OKAY));
    check_output("concurrent miss_count", 32'(miss_count), 32'd15);
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    axi_read(8'h30, d, r);
    check_output("concurrent status", d, 32'h00000201);
    axi_read(8'h2C, d, r);
    check_output("post-concurrent pop", d, 32'h01000001);
    check_output("post-concurrent count", 32'(miss_count), 32'd14);

    // Handshake ordering: W leads AW by three cycles, then B is back-pressured.
    @(posedge clk); #1;
    wdata = 32'h80000055; wvalid = 1'b1; bready = 1'b0;
    early_ready = 1'b0;
    repeat (3) begin
      #2;
      if (awready || wready) early_ready = 1'b1;
      @(posedge clk); #1;
    end
    check_output("no ready before awvalid", 32'(early_ready), 32'd0);
    awaddr = 8'h04; awvalid = 1'b1;
    #1;
    check_output("aw/w ready together", 32'({awready, wready}), 32'h3);
    @(posedge clk); #1;
    check_output("ready single cycle", 32'({awready, wready}), 32'h0);
    awvalid = 1'b0; wvalid = 1'b0;
    b_drop = 1'b0;
    repeat (4) begin
      if (!bvalid) b_drop = 1'b1;
      @(posedge clk); #1;
    end
    check_output("bvalid held under backpressure", 32'(b_drop), 32'd0);
    check_output("ordered write bresp", 32'(bresp), 32'(RESP_OKAY));
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check_output("bvalid after B", 32'(bvalid), 32'd0);
    axi_read(8'h04, d, r);
    check_output("key1 readback", d, 32'h80000055);

    // CLEAR empties both FIFOs and the drop counter; the bit reads back 0.
    axi_write(8'h20, 32'h2, r);
    axi_read(8'h34, d, r);
    check_output("clear counts", d, 32'h0);
    axi_read(8'h30, d, r);
    check_output("clear status", d, 32'h5);
    axi_read(8'h20, d, r);
    check_output("ctrl readback", d, 32'h0);
    axi_write(8'h24, 32'h55000001, r);
    for (int i = 2; i <= 5; i++) axi_write(8'h24, 32'h02000000 + 32'(i), r);
    axi_read(8'h34, d, r);
    check_output("five entries", d, 32'h00040001);
    @(posedge clk); #1;
    awaddr = 8'h20; wdata = 32'h2; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    araddr = 8'h2C; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check_output("clear next-cycle counts", 32'({match_count, miss_count}), 32'd0);
    check_output("clear pop pre-clear head", rdata, 32'h02000002);
    check_output("clear flags", 32'({match_empty, miss_empty}), 32'h3);
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;

    // Reset while BVALID is pending aborts the response.
    axi_write(8'h24, 32'h03000000, r);
    @(posedge clk); #1;
    awaddr = 8'h24; wdata = 32'h03000001; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check_output("pending bvalid", 32'(bvalid), 32'd1);
    check_output("pending miss_count", 32'(miss_count), 32'd2);
    rst_n = 1'b0;
    #1;
    check_output("reset drops bvalid", 32'(bvalid), 32'd0);
    check_output("reset clears counts", 32'({match_count, miss_count}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    axi_read(8'h04, d, r);
    check_output("key1 after reset", d, 32'h0);
    axi_read(8'h30, d, r);
    check_output("status after reset", d, 32'h5);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
